// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends an up-to-PAT_W-bit pattern MSB-first, repeated rep times.
// Optional macro SEQ_TX_GAP_EN inserts a one-cycle idle gap between repetitions.
module seq_pattern_tx #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] rep,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
`ifdef SEQ_TX_GAP_EN
      ,
      S_GAP   = 2'd3
`endif
   } state_t;

   // Index is LEN_W wide, so select by shifting rather than a narrow part-select.
   function automatic logic pick_bit(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] idx);
      logic [PAT_W-1:0] sh;
      sh = pat >> idx;
      return sh[0];
   endfunction

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [LEN_W-1:0]   eff_len_s;
   logic [BIT_W-1:0]   next_bit_s;
   logic [LEN_W-1:0]   next_idx_s;
   logic               last_bit_s;

   // Next-state and next-output logic; outputs describe the state being entered.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      rep_d      = rep_q;
      bit_d      = bit_q;
      x_d        = 1'b0;
      x_valid_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      eff_len_s  = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
      next_bit_s = bit_q + BIT_W'(1);
      next_idx_s = len_q - LEN_W'(1) - LEN_W'(next_bit_s);
      last_bit_s = (LEN_W'(bit_q) == (len_q - LEN_W'(1)));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d = pattern;
               len_d = eff_len_s;
               rep_d = rep;
               bit_d = BIT_W'(0);
               if ((eff_len_s == LEN_W'(0)) || (rep == REP_W'(0))) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = S_SHIFT;
                  x_d       = pick_bit(pattern, eff_len_s - LEN_W'(1));
                  x_valid_d = 1'b1;
                  busy_d    = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (!last_bit_s) begin
               bit_d     = next_bit_s;
               x_d       = pick_bit(pat_q, next_idx_s);
               x_valid_d = 1'b1;
               busy_d    = 1'b1;
            end else if (rep_q > REP_W'(1)) begin
               rep_d  = rep_q - REP_W'(1);
               bit_d  = BIT_W'(0);
               busy_d = 1'b1;
`ifdef SEQ_TX_GAP_EN
               state_d = S_GAP;
`else
               x_d       = pick_bit(pat_q, len_q - LEN_W'(1));
               x_valid_d = 1'b1;
`endif
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
`ifdef SEQ_TX_GAP_EN
         S_GAP: begin
            state_d   = S_SHIFT;
            x_d       = pick_bit(pat_q, len_q - LEN_W'(1));
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, shadow registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pat_q     <= PAT_W'(0);
         len_q     <= LEN_W'(0);
         rep_q     <= REP_W'(0);
         bit_q     <= BIT_W'(0);
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         rep_q     <= rep_d;
         bit_q     <= bit_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed testbench for seq_pattern_tx; captures per-cycle output traces as bit vectors.
module tb_seq_pattern_tx;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] rep;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       done;

   int pass_cnt;
   int check_cnt;

   logic [31:0] x_vec;
   logic [31:0] v_vec;
   logic [31:0] b_vec;
   logic [31:0] d_vec;

   seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .rep     (rep),
      .x       (x),
      .x_valid (x_valid),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
      pattern = p;
      len     = l;
      rep     = r;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   // Bit i of each vector is the output sampled i cycles after the start edge.
   task automatic capture(input int n, input logic [31:0] pulse_mask);
      x_vec = 32'd0; v_vec = 32'd0; b_vec = 32'd0; d_vec = 32'd0;
      for (int i = 0; i < n; i++) begin
         x_vec[i] = x;
         v_vec[i] = x_valid;
         b_vec[i] = busy;
         d_vec[i] = done;
         if (pulse_mask[i]) begin
            start = 1'b1; pattern = 8'hFF; len = 4'd8; rep = 4'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic check_traces(input string name, input logic [31:0] ex, input logic [31:0] ev,
                               input logic [31:0] eb, input logic [31:0] ed);
      check_cnt++;
      if (x_vec !== ex) $display("FAIL %s x trace: got %h expected %h", name, x_vec, ex);
      else pass_cnt++;
      check_cnt++;
      if (v_vec !== ev) $display("FAIL %s x_valid trace: got %h expected %h", name, v_vec, ev);
      else pass_cnt++;
      check_cnt++;
      if (b_vec !== eb) $display("FAIL %s busy trace: got %h expected %h", name, b_vec, eb);
      else pass_cnt++;
      check_cnt++;
      if (d_vec !== ed) $display("FAIL %s done trace: got %h expected %h", name, d_vec, ed);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0; rep = 4'd0;
      #12;
      check_cnt++;
      if ({x, x_valid, busy, done} !== 4'b0000)
         $display("FAIL reset outputs: got %b expected 0000", {x, x_valid, busy, done});
      else pass_cnt++;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      capture(3, 32'd0);
      check_traces("idle_after_reset", 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_repeat();
      launch(8'b0000_0111, 4'd3, 4'd2);
      capture(10, 32'd0);
`ifdef SEQ_TX_GAP_EN
      check_traces("111x2_gap", 32'h77, 32'h77, 32'h7F, 32'h80);
`else
      check_traces("111x2", 32'h3F, 32'h3F, 32'h3F, 32'h40);
`endif
   endtask

   task automatic test_msb_first();
      launch(8'b1011_0010, 4'd8, 4'd1);
      capture(11, 32'd0);
      check_traces("msb_first", 32'h4D, 32'hFF, 32'hFF, 32'h100);
   endtask

   task automatic test_zero();
      launch(8'hFF, 4'd3, 4'd0);
      capture(4, 32'd0);
      check_traces("rep_zero", 32'h0, 32'h0, 32'h0, 32'h1);
      launch(8'hFF, 4'd0, 4'd2);
      capture(4, 32'd0);
      check_traces("len_zero", 32'h0, 32'h0, 32'h0, 32'h1);
   endtask

   task automatic test_clamp();
      launch(8'hFF, 4'd12, 4'd1);
      capture(11, 32'd0);
      check_traces("len_clamp", 32'hFF, 32'hFF, 32'hFF, 32'h100);
   endtask

   task automatic test_reset_mid();
      launch(8'b0000_0101, 4'd3, 4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_cnt++;
      if ({x, x_valid, busy} !== 3'b111)
         $display("FAIL third_bit: got %b expected 111", {x, x_valid, busy});
      else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      check_cnt++;
      if ({x, x_valid, busy, done} !== 4'b0000)
         $display("FAIL async_drop: got %b expected 0000", {x, x_valid, busy, done});
      else pass_cnt++;
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      capture(5, 32'd0);
      check_traces("no_done_after_reset", 32'h0, 32'h0, 32'h0, 32'h0);
      launch(8'b0000_0010, 4'd2, 4'd1);
      capture(6, 32'h6);
      check_traces("start_ignored_busy_done", 32'h1, 32'h3, 32'h3, 32'h4);
   endtask

   initial begin
      pass_cnt  = 0;
      check_cnt = 0;
      test_reset();
      test_repeat();
      test_msb_first();
      test_zero();
      test_clamp();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
